mash_freq_sequencer: RTL and testbench

Frequency-word controller for the fractional-N PLL MASH chain. It accepts retune requests (integer + fractional target plus ramp step) over a valid/ready handshake. It ramps the combined word toward the target at a programmable dwell rate, drives the fractional word into the MASH modulator, and forms the instantaneous divider ratio from the integer part plus the MASH dn output. It sits between the PLL control/register logic and the MASH + multi-modulus divider.

---
 rtl/mash_pkg.sv | 25 ++
 rtl/mash_div_combine.sv | 35 +++
 rtl/mash_freq_sequencer.sv | 130 +++++++++++++
 tb/tb_mash_freq_sequencer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mash_pkg.sv
// Shared types and helpers for the MASH frequency-word sequencer and divider path.
package mash_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RAMP   = 2'd1,
    SETTLE = 2'd2
  } seq_state_e;

  // Combined {n_int,frac} word width.
  function automatic int word_w(input int nbits, input int bits);
    return nbits + bits;
  endfunction

  // Clamp a signed sum into [0, maxv]; callers truncate to their divider width.
  function automatic logic [31:0] sat_clamp(input logic signed [31:0] sum,
                                            input logic [31:0]        maxv);
    logic [31:0] u;
    u = sum;
    if (sum[31])        return '0;
    else if (u > maxv)  return maxv;
    else                return u;
  endfunction

endpackage

// File: rtl/mash_div_combine.sv
// Registered n_int + dn adder with saturation to the legal divider range.
module mash_div_combine
  import mash_pkg::*;
#(
  parameter int               NBITS   = 6,
  parameter logic [NBITS-1:0] RST_DIV = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NBITS-1:0] n_int_i,
  input  logic [3:0]       dn_i,
  output logic [NBITS-1:0] div_o
);

  localparam logic [31:0] MAXV = 32'((1 << NBITS) - 1);

  logic signed [NBITS+1:0] sum;
  logic [NBITS-1:0]        div_d;
  logic [NBITS-1:0]        div_q;

  // Sum two bits wider than n_int so both under- and overflow are visible before clamping.
  always_comb begin
    sum   = $signed({2'b00, n_int_i}) + $signed({{(NBITS-2){dn_i[3]}}, dn_i});
    div_d = NBITS'(sat_clamp({{(30-NBITS){sum[NBITS+1]}}, sum}, MAXV));
  end

  // One-cycle registered divider ratio.
  always_ff @(posedge clk) begin
    if (rst) div_q <= RST_DIV;
    else     div_q <= div_d;
  end

  assign div_o = div_q;

endmodule

// File: rtl/mash_freq_sequencer.sv
// Retune sequencer: accepts a target word, ramps toward it at a programmed
// dwell rate, holds for a settle window, and feeds the MASH/divider path.
module mash_freq_sequencer
  import mash_pkg::*;
#(
  parameter int                        BITS       = 8,
  parameter int                        NBITS      = 6,
  parameter int                        DWELL_W    = 8,
  parameter int                        SETTLE_CYC = 16,
  parameter logic [NBITS+BITS-1:0]     RESET_WORD = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [NBITS+BITS-1:0] req_target,
  input  logic [NBITS+BITS-1:0] req_step,
  input  logic [DWELL_W-1:0]    req_dwell,
  input  logic [3:0]            dn,
  output logic [BITS-1:0]       frac,
  output logic [NBITS-1:0]      n_int,
  output logic [NBITS-1:0]      div,
  output logic                  busy,
  output logic                  done
);

  localparam int W    = word_w(NBITS, BITS);
  localparam int SC_W = $clog2(SETTLE_CYC + 1);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(SETTLE_CYC - 1);

  seq_state_e         state_q;
  logic [W-1:0]       cur_q, tgt_q, step_q;
  logic [DWELL_W-1:0] dwell_q, dcnt_q;
  logic [SC_W-1:0]    scnt_q;
  logic               ready_q, busy_q, done_q;

  logic [W:0]         cur_x, tgt_x, step_x, diff;
  logic               up, hit;
  logic [W-1:0]       cur_d;

  // Next ramp point: compare in W+1 bits; when not hitting, diff > step so cur +/- step cannot wrap.
  always_comb begin
    cur_x  = {1'b0, cur_q};
    tgt_x  = {1'b0, tgt_q};
    step_x = {1'b0, step_q};
    up     = tgt_q > cur_q;
    diff   = up ? (tgt_x - cur_x) : (cur_x - tgt_x);
    hit    = diff <= step_x;
    if (hit)     cur_d = tgt_q;
    else if (up) cur_d = cur_q + step_q;
    else         cur_d = cur_q - step_q;
  end

  // Sequencer FSM with registered handshake/status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cur_q   <= RESET_WORD;
      tgt_q   <= '0;
      step_q  <= '0;
      dwell_q <= '0;
      dcnt_q  <= '0;
      scnt_q  <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid && ready_q) begin
            tgt_q   <= req_target;
            step_q  <= (req_step == '0) ? W'(1) : req_step;
            dwell_q <= req_dwell;
            dcnt_q  <= '0;
            scnt_q  <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= (req_target == cur_q) ? SETTLE : RAMP;
          end
        end
        RAMP: begin
          if (dcnt_q == dwell_q) begin
            dcnt_q <= '0;
            cur_q  <= cur_d;
            if (hit) begin
              scnt_q  <= '0;
              state_q <= SETTLE;
            end
          end else begin
            dcnt_q <= dcnt_q + 1'b1;
          end
        end
        SETTLE: begin
          if (scnt_q == SC_LAST) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            scnt_q <= scnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign frac      = cur_q[BITS-1:0];
  assign n_int     = cur_q[W-1:BITS];
  assign req_ready = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;

  mash_div_combine #(
    .NBITS   (NBITS),
    .RST_DIV (RESET_WORD[W-1:BITS])
  ) u_div (
    .clk     (clk),
    .rst     (rst),
    .n_int_i (n_int),
    .dn_i    (dn),
    .div_o   (div)
  );

endmodule

// File: tb/tb_mash_freq_sequencer.sv
// Directed bench for the MASH frequency-word sequencer.
module tb_mash_freq_sequencer;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [13:0] req_target;
  logic [13:0] req_step;
  logic [7:0]  req_dwell;
  logic [3:0]  dn;
  logic [7:0]  frac;
  logic [5:0]  n_int;
  logic [5:0]  div;
  logic        busy;
  logic        done;
  logic [13:0] cur;

  int checks = 0;
  int errors = 0;
  int n;
  int seen;

  assign cur = {n_int, frac};

  mash_freq_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_target (req_target),
    .req_step   (req_step),
    .req_dwell  (req_dwell),
    .dn         (dn),
    .frac       (frac),
    .n_int      (n_int),
    .div        (div),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Ticks until done is seen (bounded); n = number of edges waited.
  task automatic wait_done(output int cnt);
    cnt = 0;
    while (!done && cnt < 100) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_target = '0; req_step = '0; req_dwell = '0; dn = '0;
    repeat (2) tick();
    chk("rst_frac", frac, 0);
    chk("rst_nint", n_int, 0);
    chk("rst_div", div, 0);
    chk("rst_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    tick();
    chk("idle_div", div, 0);

    // Jump to 0x0A00 in one update
    req_valid = 1'b1; req_target = 14'h0A00; req_step = 14'h3FFF; req_dwell = 8'd0;
    tick();
    req_valid = 1'b0;
    chk("jump_busy", busy, 1);
    chk("jump_ready", req_ready, 0);
    chk("jump_cur0", cur, 14'h0000);
    wait_done(n);
    chk("jump_lat", n, 17);
    chk("jump_cur", cur, 14'h0A00);
    chk("jump_div", div, 10);
    chk("done_busy", busy, 0);
    chk("done_ready", req_ready, 1);

    // Up ramp accepted in the done cycle
    req_valid = 1'b1; req_target = 14'h0A80; req_step = 14'h0040; req_dwell = 8'd3;
    tick();
    // Hold the next (down) request during the ramp; must not be taken early
    req_target = 14'h0A10; req_step = 14'h0050; req_dwell = 8'd1;
    chk("b2b_busy", busy, 1);
    chk("b2b_done_clr", done, 0);
    chk("up_ready", req_ready, 0);
    repeat (3) tick();
    chk("up_hold0", cur, 14'h0A00);
    tick();
    chk("up_step1", cur, 14'h0A40);
    repeat (3) tick();
    chk("up_hold1", cur, 14'h0A40);
    tick();
    chk("up_step2", cur, 14'h0A80);
    chk("up_noacc", req_ready, 0);
    wait_done(n);
    chk("up_settle", n, 16);
    chk("up_done_ready", req_ready, 1);
    chk("up_done_busy", busy, 0);
    chk("up_done_cur", cur, 14'h0A80);

    // Held down request accepted in the done cycle
    tick();
    req_valid = 1'b0;
    chk("dn_busy", busy, 1);
    repeat (2) tick();
    chk("dn_step1", cur, 14'h0A30);
    repeat (2) tick();
    chk("dn_clamp", cur, 14'h0A10);
    wait_done(n);
    chk("dn_settle", n, 16);
    tick();
    chk("done_pulse", done, 0);

    // Divider combine at n_int=10
    dn = 4'hE; tick(); chk("div_m2", div, 8);
    dn = 4'h4; tick(); chk("div_p4", div, 14);
    dn = 4'h8; tick(); chk("div_m8", div, 2);
    dn = 4'h7; tick(); chk("div_p7", div, 17);
    dn = 4'h0;

    // Zero step behaves as step of 1
    req_valid = 1'b1; req_target = 14'h0A12; req_step = 14'h0000; req_dwell = 8'd0;
    tick();
    req_valid = 1'b0;
    tick(); chk("step0_a", cur, 14'h0A11);
    tick(); chk("step0_b", cur, 14'h0A12);
    chk("step0_busy", busy, 1);
    wait_done(n);
    chk("step0_settle", n, 16);

    // Target equal to cur goes straight to settle
    req_valid = 1'b1; req_target = 14'h0A12; req_step = 14'h0005; req_dwell = 8'd9;
    tick();
    req_valid = 1'b0;
    chk("eq_busy", busy, 1);
    wait_done(n);
    chk("eq_settle", n, 16);
    chk("eq_cur", cur, 14'h0A12);

    // Underflow clamp at n_int=0
    rst = 1'b1; tick(); rst = 1'b0;
    dn = 4'hD;
    chk("rst2_cur", cur, 14'h0000);
    tick();
    chk("div_lo_sat", div, 0);
    dn = 4'h0;

    // Overflow clamp at n_int=63
    req_valid = 1'b1; req_target = 14'h3F00; req_step = 14'h3FFF; req_dwell = 8'd0;
    tick();
    req_valid = 1'b0;
    wait_done(n);
    chk("top_lat", n, 17);
    dn = 4'h4; tick(); chk("div_hi_sat4", div, 63);
    dn = 4'h7; tick(); chk("div_hi_sat7", div, 63);
    dn = 4'hF; tick(); chk("div_hi_m1", div, 62);
    dn = 4'h0;

    // Reset mid-ramp
    req_valid = 1'b1; req_target = 14'h0000; req_step = 14'h0100; req_dwell = 8'd2;
    tick();
    req_valid = 1'b0;
    repeat (3) tick();
    chk("mid_step", cur, 14'h3E00);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mid_cur", cur, 14'h0000);
    chk("mid_busy", busy, 0);
    chk("mid_ready", req_ready, 1);
    chk("mid_done", done, 0);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done || busy || cur != 14'h0000) seen++;
    end
    chk("mid_quiet", seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
